// File: rtl/gpc231_4_accum_ctrl_pkg.sv
// Shared types and constants for the gpc231_4 accumulate controller.
// Holds the controller state encoding and the counter's port geometry.
package gpc_pkg;

  localparam int GPC231_IN_W    = 6;
  localparam int GPC231_OUT_W   = 4;
  localparam int GPC231_MAX_SUM = 15;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    OUTPUT
  } state_e;

endpackage

// File: rtl/gpc231_4_accum_ctrl_if.sv
// Beat-in / result-out handshake bundle of the accumulate controller.
// The master is the beat source and result consumer; the slave is the controller.
interface gpc231_4_accum_ctrl_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic             src0;
  logic [2:0]       src1;
  logic [1:0]       src2;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_last, src0, src1, src2, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_last, src0, src1, src2, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/gpc231_4_accum_ctrl_gpc.sv
// gpc231_4 generalized parallel counter: one weight-1, three weight-2 and
// two weight-4 bits compressed into a 4-bit sum (0..15).
module gpc231_4
  import gpc_pkg::*;
(
  input  logic                    src0,
  input  logic [2:0]              src1,
  input  logic [1:0]              src2,
  output logic [GPC231_OUT_W-1:0] dst
);

  logic [1:0] pc1;
  logic [1:0] pc2;

  assign pc1 = {1'b0, src1[0]} + {1'b0, src1[1]} + {1'b0, src1[2]};
  assign pc2 = {1'b0, src2[0]} + {1'b0, src2[1]};
  assign dst = {3'b000, src0} + {1'b0, pc1, 1'b0} + {pc2, 2'b00};

endmodule

// File: rtl/gpc231_4_accum_ctrl.sv
// Time-multiplexes one gpc231_4 over a packet of beats: stage 1 registers the
// counter output, stage 2 accumulates, and the FSM hands the total downstream.
module gpc231_4_accum_ctrl
  import gpc_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gpc231_4_accum_ctrl_if.slave bus
);

  state_e                  state_q, state_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic [GPC231_OUT_W-1:0] s1_sum_q, s1_sum_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;

  logic [GPC231_OUT_W-1:0] gpc_dst;
  logic [ACC_W:0]          acc_sum;
  logic                    in_ready_c;
  logic                    out_valid_c;
  logic                    accept;
  logic                    consume;

  gpc231_4 u_gpc (
    .src0 (bus.src0),
    .src1 (bus.src1),
    .src2 (bus.src2),
    .dst  (gpc_dst)
  );

  assign accept  = bus.in_valid && in_ready_c;
  assign consume = out_valid_c && bus.out_ready;
  // The extra top bit is the wrap carry that feeds the sticky overflow flag.
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(s1_sum_q);

  // NOTE: every signal gets its default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (s1_valid_q && s1_last_q) state_d = OUTPUT;
      end
      OUTPUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    s1_valid_d = accept;
    s1_sum_d   = s1_sum_q;
    s1_last_d  = s1_last_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    if (accept) begin
      s1_sum_d  = gpc_dst;
      s1_last_d = bus.in_last;
    end
    if (consume) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (s1_valid_q) begin
      acc_d = acc_sum[ACC_W-1:0];
      ovf_d = ovf_q | acc_sum[ACC_W];
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments; rst is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_sum_q   <= s1_sum_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_gpc231_4_accum_ctrl.sv
// Bench for gpc231_4_accum_ctrl: directed and randomized packets checked
// against a packet-level arithmetic model of the expected result.
module tb_gpc231_4_accum_ctrl;

  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam int ACC_MOD = 1 << ACC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gpc231_4_accum_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  gpc231_4_accum_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_total = 0;
  int model_beats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Weighted popcount of one beat: src0*1 + popcount(src1)*2 + popcount(src2)*4.
  function automatic int ref_sum(input logic [5:0] code);
    return int'(code[0]) + 2 * $countones(code[3:1]) + 4 * $countones(code[5:4]);
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'($urandom);
    {bus.src2, bus.src1, bus.src0} = 6'($urandom);
  endtask

  // Present one beat from a negedge and return at the negedge after acceptance.
  task automatic drive_beat(input logic [5:0] code, input logic last);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("in_ready_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    {bus.src2, bus.src1, bus.src0} = code;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic send_beat(input logic [5:0] code, input logic last, input int gap);
    repeat (gap) begin
      idle_inputs();
      @(negedge clk);
    end
    drive_beat(code, last);
    model_total += ref_sum(code);
    model_beats++;
    if (last) begin
      check("t1_in_ready", 32'(bus.in_ready), 0);
      check("t1_out_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
      check("t2_out_valid", 32'(bus.out_valid), 1);
    end
  endtask

  // Check the pending result, hold it under backpressure, then consume it.
  task automatic expect_result(input int hold);
    int exp_data;
    int exp_cnt;
    int exp_ovf;
    exp_data = model_total % ACC_MOD;
    exp_cnt  = (model_beats > CNT_MAX) ? CNT_MAX : model_beats;
    exp_ovf  = (model_total >= ACC_MOD) ? 1 : 0;
    check("res_out_valid", 32'(bus.out_valid), 1);
    check("res_in_ready", 32'(bus.in_ready), 0);
    check("res_data", 32'(bus.out_data), 32'(exp_data));
    check("res_count", 32'(bus.out_count), 32'(exp_cnt));
    check("res_ovf", 32'(bus.out_ovf), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom);
      bus.in_last   = 1'b1;
      {bus.src2, bus.src1, bus.src0} = 6'($urandom);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_in_ready", 32'(bus.in_ready), 0);
      check("hold_data", 32'(bus.out_data), 32'(exp_data));
      check("hold_count", 32'(bus.out_count), 32'(exp_cnt));
      check("hold_ovf", 32'(bus.out_ovf), 32'(exp_ovf));
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_out_valid", 32'(bus.out_valid), 0);
    check("post_in_ready", 32'(bus.in_ready), 1);
    check("post_data", 32'(bus.out_data), 0);
    check("post_count", 32'(bus.out_count), 0);
    check("post_ovf", 32'(bus.out_ovf), 0);
    model_total = 0;
    model_beats = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_data"}, 32'(bus.out_data), 0);
    check({tag, "_count"}, 32'(bus.out_count), 0);
    check({tag, "_ovf"}, 32'(bus.out_ovf), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Single full-weight beat: 15, count 1, no wrap.
    send_beat(6'h3f, 1'b1, 0);
    expect_result(0);

    // Three-beat packet 15 + 1 + 8.
    send_beat(6'h3f, 1'b0, 0);
    send_beat(6'h01, 1'b0, 0);
    send_beat(6'h30, 1'b1, 0);
    expect_result(0);

    // 18 x 15 = 270 wraps to 14 with overflow, then a clean packet.
    for (int i = 0; i < 18; i++) send_beat(6'h3f, (i == 17), 0);
    expect_result(0);
    send_beat(6'h02, 1'b1, 0);
    expect_result(0);

    // Backpressure: 24 pending for 5 cycles with stray in_valid pulses.
    send_beat(6'h3f, 1'b0, 0);
    send_beat(6'h01, 1'b0, 1);
    send_beat(6'h30, 1'b1, 2);
    expect_result(5);

    // Mid-packet reset discards the partial sum.
    drive_beat(6'h3f, 1'b0);
    drive_beat(6'h3f, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    check("midrst_no_result", 32'(bus.out_valid), 0);
    send_beat(6'h04, 1'b1, 0);
    expect_result(0);

    // Every code as a single-beat packet.
    for (int c = 0; c < 64; c++) begin
      send_beat(6'(c), 1'b1, 0);
      expect_result(0);
    end

    // Counter saturation: 260 beats of weight 1.
    for (int i = 0; i < 260; i++) send_beat(6'h01, (i == 259), 0);
    expect_result(1);

    // Random packets with input gaps and result backpressure.
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 30);
      for (int b = 0; b < len; b++)
        send_beat(6'($urandom), (b == len - 1), $urandom_range(0, 2));
      expect_result($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
